// File: rtl/mul_rr_scheduler.sv
// Round-robin front end sharing one signed 16x16 Booth/Wallace multiplier among NREQ requesters.
// Two registers (issue, response) bound the multiplier path; response channel has full backpressure.

module TopMultiplier (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [31:0] p
);
    logic [31:0] xe;
    logic [16:0] yb;
    logic [31:0] pp [8];
    logic [31:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

    function automatic logic [31:0] booth_pp(input logic [2:0] sel, input logic [31:0] xv);
        case (sel)
            3'b001, 3'b010: booth_pp = xv;
            3'b011:         booth_pp = xv << 1;
            3'b100:         booth_pp = -(xv << 1);
            3'b101, 3'b110: booth_pp = -xv;
            default:        booth_pp = '0;
        endcase
    endfunction

    // 3:2 compressor; returns {carry, sum}, all arithmetic modulo 2^32
    function automatic logic [63:0] csa(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        csa = {((a & b) | (a & c) | (b & c)) << 1, a ^ b ^ c};
    endfunction

    assign xe = {{16{x[15]}}, x};
    assign yb = {y, 1'b0};

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pp
            assign pp[gi] = booth_pp(yb[2*gi+2 -: 3], xe) << (2 * gi);
        end
    endgenerate

    assign {c0, s0} = csa(pp[0], pp[1], pp[2]);
    assign {c1, s1} = csa(pp[3], pp[4], pp[5]);
    assign {c2, s2} = csa(s0, c0, s1);
    assign {c3, s3} = csa(c1, pp[6], pp[7]);
    assign {c4, s4} = csa(s2, c2, s3);
    assign {c5, s5} = csa(s4, c4, c3);
    assign p = s5 + c5;
endmodule

module mul_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 busy
);
    logic            a_valid_q, a_valid_d;
    logic [15:0]     a_x_q, a_x_d, a_y_q, a_y_d;
    logic [ID_W-1:0] a_id_q, a_id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;

    logic [15:0]     x_arr [NREQ];
    logic [15:0]     y_arr [NREQ];
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    int              arb_idx;
    logic            b_free, a_free, handshake;
    logic [31:0]     product;

    assign b_free    = !rsp_valid_q | rsp_ready;
    assign a_free    = !a_valid_q | b_free;
    assign handshake = |(req_valid & req_ready);

    // Ready is also held low while in reset so no requester believes a pair was taken.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign x_arr[gi]     = req_x[16*gi +: 16];
            assign y_arr[gi]     = req_y[16*gi +: 16];
            assign req_ready[gi] = rst_n & grant_found & a_free & (grant_id == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        arb_idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            arb_idx = int'(ptr_q) + k;
            if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
            if (!grant_found && req_valid[arb_idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(arb_idx);
            end
        end
    end

    TopMultiplier u_mult (
        .x(a_x_q),
        .y(a_y_q),
        .p(product)
    );

    always_comb begin
        a_valid_d   = a_valid_q;
        a_x_d       = a_x_q;
        a_y_d       = a_y_q;
        a_id_d      = a_id_q;
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;

        if (handshake) begin
            a_valid_d = 1'b1;
            a_x_d     = x_arr[grant_id];
            a_y_d     = y_arr[grant_id];
            a_id_d    = grant_id;
            ptr_d     = grant_id;
        end else if (a_free) begin
            a_valid_d = 1'b0;
        end

        if (a_valid_q && b_free) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = product;
            rsp_id_d    = a_id_q;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q   <= 1'b0;
            a_x_q       <= '0;
            a_y_q       <= '0;
            a_id_q      <= '0;
            ptr_q       <= ID_W'(NREQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_x_q       <= a_x_d;
            a_y_q       <= a_y_d;
            a_id_q      <= a_id_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = a_valid_q | rsp_valid_q;
endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Bench for mul_rr_scheduler: directed scenarios plus randomized traffic checked against
// an in-order scoreboard with a minimum one-cycle issue latency and two-entry capacity.

module tb_mul_rr_scheduler;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [16*NREQ-1:0]  req_x, req_y;
    logic                rsp_valid, rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [31:0]         rsp_data;
    logic                busy;

    mul_rr_scheduler #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int          id;
        logic [31:0] p;
        bit          vis;
    } ent_t;

    ent_t            q[$];
    int              m_ptr;
    int              m_grant;
    bit              m_cons;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] obs_ready;
    logic            obs_valid, obs_busy;
    logic [ID_W-1:0] obs_id;
    logic [31:0]     obs_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        longint prod;
        prod = longint'($signed(x)) * longint'($signed(y));
        return prod[31:0];
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] rand16();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y);
        req_valid[i]     = 1'b1;
        req_x[16*i +: 16] = x;
        req_y[16*i +: 16] = y;
    endtask

    // Reference: next valid requester after the last grant; accept while fewer than two
    // results are outstanding or the oldest one is being consumed this cycle.
    task automatic model_predict();
        int idx;
        m_grant = -1;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (m_grant < 0 && req_valid[idx]) m_grant = idx;
        end
        m_cons    = (q.size() > 0) && q[0].vis && rsp_ready;
        exp_ready = '0;
        if (m_grant >= 0 && (q.size() < 2 || m_cons)) exp_ready[m_grant] = 1'b1;
    endtask

    // Called at posedge+1 with inputs already driven; checks at the falling edge.
    task automatic cycle();
        bit exp_v;
        #4;
        model_predict();
        obs_ready = req_ready;
        obs_valid = rsp_valid;
        obs_busy  = busy;
        obs_id    = rsp_id;
        obs_data  = rsp_data;
        exp_v     = (q.size() > 0) && q[0].vis;
        check("req_ready", obs_ready, exp_ready);
        check("rsp_valid", obs_valid, exp_v);
        check("busy", obs_busy, q.size() > 0);
        if (exp_v) begin
            check("rsp_id", obs_id, q[0].id);
            check("rsp_data", obs_data, q[0].p);
            if (rsp_ready) $display("rsp id=%0d data=%08h", obs_id, obs_data);
        end
        @(posedge clk);
        if (m_cons) q.delete(0);
        if (q.size() > 0) q[0].vis = 1'b1;
        if (exp_ready != '0) begin
            q.push_back('{m_grant, ref_mul(req_x[16*m_grant +: 16], req_y[16*m_grant +: 16]), 1'b0});
            m_ptr = m_grant;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        q.delete();
        m_ptr = NREQ - 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] cx [3];
        logic [15:0] cy [3];
        logic [31:0] cp [3];
        int          fair_ord [6];
        int          skip_ord [4];
        int          acc;

        cx = '{16'h8000, 16'h7FFF, 16'h0000};
        cy = '{16'h8000, 16'h8000, 16'hFFFF};
        cp = '{32'h40000000, 32'hC0008000, 32'h00000000};
        fair_ord = '{0, 1, 2, 3, 0, 1};
        skip_ord = '{2, 0, 2, 0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b0;
        m_ptr     = NREQ - 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_data", rsp_data, 32'h0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_busy", busy, 1'b0);
        check("reset_req_ready", req_ready, 0);
        rst_n = 1'b1;

        // Single multiply from requester 1
        rsp_ready = 1'b1;
        set_req(1, 16'hFFFD, 16'h0007);
        cycle();
        check("single_ready", obs_ready, 4'b0010);
        req_valid = '0;
        cycle();
        cycle();
        check("single_valid", obs_valid, 1'b1);
        check("single_data", obs_data, 32'hFFFFFFEB);
        check("single_id", obs_id, 1);
        cycle();

        // Corner products
        for (int i = 0; i < 3; i++) begin
            set_req(0, cx[i], cy[i]);
            cycle();
            req_valid = '0;
            cycle();
            cycle();
            check("corner_valid", obs_valid, 1'b1);
            check("corner_data", obs_data, cp[i]);
        end
        cycle();

        // Round-robin fairness with everyone requesting
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, rand16(), rand16());
        for (int c = 0; c < 6; c++) begin
            cycle();
            check("fair_grant", onehot_idx(obs_ready), fair_ord[c]);
            if (c >= 2) check("fair_rsp_id", obs_id, fair_ord[c-2]);
        end
        req_valid = '0;
        repeat (3) cycle();

        // Idle requesters are skipped
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 16'h0003, 16'h0005);
        cycle();
        req_valid = '0;
        cycle();
        set_req(0, rand16(), rand16());
        set_req(2, rand16(), rand16());
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("skip_grant", onehot_idx(obs_ready), skip_ord[c]);
        end
        req_valid = '0;
        repeat (3) cycle();

        // Backpressure: two entries buffer, then ready drops
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, rand16(), rand16());
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (obs_ready != '0) acc++;
            if (c >= 2) check("bp_ready_low", obs_ready, 0);
        end
        check("bp_accepted", acc, 2);
        rsp_ready = 1'b1;
        repeat (8) cycle();
        req_valid = '0;
        repeat (3) cycle();

        // Reset while both stages are full
        for (int i = 0; i < NREQ; i++) set_req(i, rand16(), rand16());
        rsp_ready = 1'b0;
        cycle();
        cycle();
        check("pre_rst_busy", obs_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, 0);
        q.delete();
        m_ptr = NREQ - 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        cycle();
        check("rst_first_grant", obs_ready, 4'b0001);
        req_valid = '0;
        repeat (3) cycle();

        // Randomized traffic with random backpressure and dropped requests
        for (int c = 0; c < 600; c++) begin
            if ((c / 25) % 4 == 3) rsp_ready = ($urandom_range(0, 7) == 0);
            else                   rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 1) == 1) set_req(i, rand16(), rand16());
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (obs_ready[i]) begin
                    if ($urandom_range(0, 1) == 1) set_req(i, rand16(), rand16());
                    else req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) cycle();
        check("final_busy", obs_busy, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mul_rr_scheduler.md
# mul_rr_scheduler

Round-robin scheduler that shares one 16-bit signed Booth/Wallace multiplier datapath (`TopMultiplier`) between `NREQ` independent requesters. It arbitrates valid/ready requests and registers the winning operands into the combinational multiplier. It captures the product with the requester ID in an output register and returns it on a single valid/ready response channel with full backpressure. Sustained throughput is one multiply per cycle; the multiplier's combinational path is bounded by two pipeline registers.

## Interface

- `NREQ`, 4, number of requesters (2..8).
- `ID_W`, 2, width of the requester index; must equal clog2(NREQ), minimum 1.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised externally to `clk`.
- `req_valid`  input  NREQ  bit i: requester i presents an operand pair.
- `req_ready`  output  NREQ  bit i: requester i's pair is accepted this cycle. At most one bit is high.
- `req_x`  input  16*NREQ  multiplicand. Slice [16i+15:16i] belongs to requester i; two's complement.
- `req_y`  input  16*NREQ  multiplier. Same slicing as `req_x`.
- `rsp_valid`  output  1  response register holds a result.
- `rsp_ready`  input  1  consumer accepts the response.
- `rsp_id`  output  ID_W  index of the requester that issued the result.
- `rsp_data`  output  32  signed product x*y.
- `busy`  output  1  high when either pipeline stage holds a valid entry.

## Operation

- **Stage A (issue register):** `a_valid`, `a_x`, `a_y`, `a_id`. The `TopMultiplier` instance is driven from `a_x`/`a_y`.
- **Stage B (response register):** `rsp_valid`, `rsp_data`, `rsp_id`. Loaded from the multiplier output and `a_id`.
- **Stage B load condition:** `b_free = !rsp_valid | rsp_ready`.
- **Stage A load condition:** `a_free = !a_valid | b_free`.
- **Arbitration:** combinational round-robin over `req_valid`.
  - Search starts at `ptr+1` modulo NREQ.
  - Winner g: `req_ready[g] = a_free`. All other ready bits are 0.
  - If no `req_valid` bit is set, all ready bits are 0.
- **Handshake on requester g** (`req_valid[g] & req_ready[g]`): at the edge, `a_x`/`a_y`/`a_id` load requester g's slices, `a_valid` is set, and `ptr` becomes g.
- **Pointer hold:** `ptr` does not change in any cycle without a handshake.
- **Stage A without a new handshake:** if `a_free` is high and no handshake occurs, `a_valid` clears.
- **Stage A to B transfer:** if `a_valid & b_free`, stage B loads the product and `a_id`, and `rsp_valid` is set.
- **Stage B drain:** else if `rsp_ready`, `rsp_valid` clears.
- **Requester rules:** a requester holds `req_valid` and its operands stable until it sees ready. The block never accepts data that ready did not qualify. Deasserting valid before ready is allowed and drops that request without side effects.
- **Ordering:** responses leave in acceptance order. No entry is dropped or duplicated under any backpressure pattern.
- **Arithmetic:** signed 16x16 to 32-bit, exact, with no overflow case. 0x8000*0x8000 = 0x40000000.
- **`busy`** = `a_valid | rsp_valid`.

## Timing

- **Reset values:**
  - `req_ready` = 0 (because `a_free` is high but there is no valid).
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `busy` = 0.
  - `a_valid` = 0, `ptr` = NREQ-1, so requester 0 has first priority.
- **Latency:** a handshake at edge E0 gives `rsp_valid` high after edge E1, provided `b_free` is high in the cycle between E0 and E1.
- **Throughput:** with `rsp_ready` held high, one acceptance per cycle and one response per cycle.
- **Stall:**
  - `rsp_ready` low with both stages full gives `b_free` = 0 and `a_free` = 0, so all `req_ready` bits go low in the same cycle (combinational).
  - When `rsp_ready` rises, `req_ready` may rise in that same cycle (full pass-through, no bubble).
- **Simultaneous events:** in one cycle the block may consume a response, advance stage A to B, and accept a new request at the same edge.
- **Reset mid-operation:** both stages are discarded immediately on `rst_n` low. In-flight products are lost and `ptr` returns to NREQ-1.
- **Combinational path:** `req_ready` depends on `req_valid`, `ptr`, `a_valid`, `rsp_valid` and `rsp_ready`. There is no path from `req_x`/`req_y` to any output within a cycle.

## Test plan

- **Single multiply:** reset, then requester 1 sends x=-3 (0xFFFD), y=7 -> `req_ready[1]` high in the same cycle; `rsp_valid` high one edge later with `rsp_data` = 0xFFFFFFEB, `rsp_id` = 1.
- **Corner products:** 0x8000*0x8000 -> 0x40000000; 0x7FFF*0x8000 -> 0xC0008000; 0*0xFFFF -> 0.
- **Round-robin fairness:** all four requesters hold valid continuously with `rsp_ready` = 1 -> grant order 0,1,2,3,0,1 on consecutive cycles; responses carry the same ID order one edge behind.
- **Skipping idle requesters:** only requesters 0 and 2 valid, starting with `ptr` = 0 -> grants alternate 2,0,2,0; requesters 1 and 3 are never granted.
- **Backpressure:** continuous requests, `rsp_ready` = 0 for 4 cycles -> exactly two entries buffered and `req_ready` all low after the second acceptance; on release, the two results drain in order, then acceptance resumes with no loss or duplication (scoreboard against a reference model).
- **Reset mid-operation:** both stages full, assert `rst_n` low between edges -> `rsp_valid`, `busy` and `req_ready` go to 0 asynchronously; after release, the first grant goes to requester 0.
